// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment type, blank code and the hex glyph table.
// Segment vectors are active-low, bit 0 = a ... bit 6 = g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t SEG_LUT [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-side signal bundle between a display source and the scan driver.
// The source (master) supplies value/dp/control, the driver (slave) returns pin levels.
interface seg7_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int N_DIGITS = 8
);

  logic [4*N_DIGITS-1:0] value_in;
  logic [N_DIGITS-1:0]   dp_in;
  logic                  en;
  logic                  lz_blank;
  seg_t                  cc;
  logic                  dp;
  logic [N_DIGITS-1:0]   an;
  logic                  frame_start;

  modport master (
    output value_in, dp_in, en, lz_blank,
    input  cc, dp, an, frame_start
  );

  modport slave (
    input  value_in, dp_in, en, lz_blank,
    output cc, dp, an, frame_start
  );

endinterface

// File: rtl/seg7_scan_driver_hex_to_seg.sv
// Hex nibble to active-low 7-segment glyph; purely combinational and reusable
// by any display block that needs the standard 0-F font.
module hex_to_seg
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output seg_t       seg
);

  // Table lookup; every 4-bit code has a glyph so no fallback is needed.
  always_comb begin
    seg = SEG_LUT[hex];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex display driver: prescaled digit scan, per-frame snapshot,
// leading-zero suppression and start-of-slot blanking, all outputs registered.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [DIV_W-1:0]      div_cnt_r;
  logic [IDX_W-1:0]      digit_idx_r;
  logic [4*N_DIGITS-1:0] frame_val_r;
  logic                  frame_start_r;
  seg_t                  cc_r;
  logic                  dp_r;
  logic [N_DIGITS-1:0]   an_r;

  logic                  tick_s;
  logic                  last_digit_s;
  logic                  past_blank_s;
  logic [N_DIGITS-1:0]   onehot_s;
  logic [N_DIGITS-1:0]   upper_zero_s;
  logic [3:0]            nibble_s;
  logic                  dp_req_s;
  logic                  suppress_s;
  logic                  lit_s;
  seg_t                  seg_s;

  assign tick_s       = (div_cnt_r == DIV_W'(REFRESH_DIV - 1));
  assign last_digit_s = (digit_idx_r == IDX_W'(N_DIGITS - 1));

  // A zero blanking window would make the comparison constant, so skip it entirely.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign past_blank_s = 1'b1;
    end else begin : g_blank
      assign past_blank_s = (div_cnt_r >= DIV_W'(BLANK_CYCLES));
    end
  endgenerate

  // Digit select, nibble/dp mux and "this digit and everything above it is zero" flags.
  always_comb begin
    onehot_s     = {N_DIGITS{1'b0}};
    upper_zero_s = {N_DIGITS{1'b0}};
    nibble_s     = 4'h0;
    dp_req_s     = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      onehot_s[i]     = (digit_idx_r == IDX_W'(i));
      upper_zero_s[i] = ((frame_val_r >> (4 * i)) == {(4*N_DIGITS){1'b0}});
      nibble_s        = nibble_s | (frame_val_r[4*i +: 4] & {4{onehot_s[i]}});
      dp_req_s        = dp_req_s | (bus.dp_in[i] & onehot_s[i]);
    end
  end

  // Digit 0 is never suppressed so an all-zero word still shows a single 0.
  assign suppress_s = bus.lz_blank && !onehot_s[0] && (|(onehot_s & upper_zero_s));
  assign lit_s      = bus.en && past_blank_s && !suppress_s;

  hex_to_seg u_hex_to_seg (
    .hex (nibble_s),
    .seg (seg_s)
  );

  // Prescaler, digit scan and frame snapshot; value_in is only sampled at the frame wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_r     <= {DIV_W{1'b0}};
      digit_idx_r   <= {IDX_W{1'b0}};
      frame_val_r   <= {(4*N_DIGITS){1'b0}};
      frame_start_r <= 1'b0;
    end else if (tick_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      if (last_digit_s) begin
        digit_idx_r   <= {IDX_W{1'b0}};
        frame_val_r   <= bus.value_in;
        frame_start_r <= 1'b1;
      end else begin
        digit_idx_r   <= digit_idx_r + IDX_W'(1);
        frame_start_r <= 1'b0;
      end
    end else begin
      div_cnt_r     <= div_cnt_r + DIV_W'(1);
      frame_start_r <= 1'b0;
    end
  end

  // Pin registers, computed from the current scan state (one cycle behind it).
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_r <= SEG_BLANK;
      dp_r <= 1'b1;
      an_r <= {N_DIGITS{1'b1}};
    end else if (lit_s) begin
      cc_r <= seg_s;
      dp_r <= ~dp_req_s;
      an_r <= ~onehot_s;
    end else begin
      cc_r <= SEG_BLANK;
      dp_r <= 1'b1;
      an_r <= {N_DIGITS{1'b1}};
    end
  end

  assign bus.cc          = cc_r;
  assign bus.dp          = dp_r;
  assign bus.an          = an_r;
  assign bus.frame_start = frame_start_r;

endmodule
